// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - access widths, store-buffer entry and lane helpers for mem_stage_sb
package mem_pkg;

  typedef enum logic [1:0] {
    MW_BYTE   = 2'b00,
    MW_HALF   = 2'b01,
    MW_WORD   = 2'b10,
    MW_DOUBLE = 2'b11
  } mem_width_e;

  // Entry fields are sized for the widest legal configuration; narrower builds leave upper bits zero.
  localparam int SB_IDX_W  = 32;
  localparam int SB_DATA_W = 64;
  localparam int SB_MASK_W = 8;

  typedef struct packed {
    logic [SB_IDX_W-1:0]  idx;
    logic [SB_DATA_W-1:0] data;
    logic [SB_MASK_W-1:0] mask;
  } sb_entry_t;

  function automatic logic [SB_MASK_W-1:0] mem_lane_mask(input mem_width_e w, input logic [2:0] off);
    logic [SB_MASK_W-1:0] m;
    case (w)
      MW_BYTE: m = 8'h01;
      MW_HALF: m = 8'h03;
      MW_WORD: m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << off;
  endfunction

  function automatic logic [SB_DATA_W-1:0] mem_extend(input logic [SB_DATA_W-1:0] d,
                                                      input mem_width_e w, input logic sx);
    logic [SB_DATA_W-1:0] r;
    case (w)
      MW_BYTE: r = {{56{sx & d[7]}}, d[7:0]};
      MW_HALF: r = {{48{sx & d[15]}}, d[15:0]};
      MW_WORD: r = {{32{sx & d[31]}}, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_store_buf.sv
// rtl/mem_store_buf.sv - FIFO of posted stores with per-entry word-index hit vector
module mem_store_buf
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_push,
  input  sb_entry_t           i_push_entry,
  input  logic                i_pop,
  input  logic [SB_IDX_W-1:0] i_cmp_idx,
  output sb_entry_t           o_head,
  output logic [DEPTH-1:0]    o_hit,
  output logic                o_full,
  output logic                o_empty
);
  localparam int PW = $clog2(DEPTH);

  sb_entry_t        r_ent [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  // No full-bypass: a push is refused while full even if the head pops this cycle.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_ent[r_head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + 1'b1;
      end
      if (w_push) begin
        r_vld[r_tail] <= 1'b1;
        r_tail        <= r_tail + 1'b1;
      end
      r_count <= r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_ent[r_tail] <= i_push_entry;
  end

  always_comb begin
    o_hit = '0;
    for (int i = 0; i < DEPTH; i++) o_hit[i] = r_vld[i] && (r_ent[i].idx == i_cmp_idx);
  end

endmodule

// File: rtl/mem_stage_sb.sv
// rtl/mem_stage_sb.sv - data-memory stage with posted-store buffer and 1-cycle registered loads
// Optional: MEM_STAGE_MISALIGN_CHECK_EN flags and suppresses misaligned accesses.
module mem_stage_sb
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int SB_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [1:0]            req_width,
  input  logic                  req_sign_ext,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  sb_empty,
  output logic                  misaligned
);
  localparam int LANES = DATA_WIDTH / 8;
  localparam int OFFW  = $clog2(LANES);
  localparam int WORDS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_ram [WORDS];
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rvalid;

  mem_width_e            w_width;
  logic [2:0]            w_size_m1;
  logic [OFFW-1:0]       w_off;
  logic [OFFW-1:0]       w_off_eff;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_mis;
  logic                  w_acc;
  logic                  w_ld_go;
  logic                  w_st_go;
  logic                  w_drain;
  logic                  w_sb_full;
  logic [SB_DEPTH-1:0]   w_hit;
  sb_entry_t             w_push_entry;
  sb_entry_t             w_head;
  logic [SB_DATA_W-1:0]  w_rd_sh;
  logic [SB_DATA_W-1:0]  w_ext;
  logic                  w_unused;

  assign w_width = (DATA_WIDTH == 32 && req_width == 2'b11) ? MW_WORD : mem_width_e'(req_width);
  assign w_off   = req_addr[OFFW-1:0];
  assign w_idx   = req_addr[ADDR_WIDTH+OFFW-1:OFFW];

  always_comb begin
    w_size_m1 = 3'd7;
    case (w_width)
      MW_BYTE: w_size_m1 = 3'd0;
      MW_HALF: w_size_m1 = 3'd1;
      MW_WORD: w_size_m1 = 3'd3;
      default: w_size_m1 = 3'd7;
    endcase
  end

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
  assign w_mis     = |(w_off & w_size_m1[OFFW-1:0]);
  assign w_off_eff = w_off;
`else
  assign w_mis     = 1'b0;
  assign w_off_eff = w_off & ~w_size_m1[OFFW-1:0];
`endif

  // Misaligned accesses are no-ops, so they never wait on the buffer.
  assign req_ready = w_mis || (req_we ? !w_sb_full : !(|w_hit));
  assign w_acc     = req_valid && req_ready;
  assign w_ld_go   = w_acc && !req_we && !w_mis;
  assign w_st_go   = w_acc && req_we && !w_mis;
  assign w_drain   = !w_ld_go && !sb_empty;

  always_comb begin
    w_push_entry      = '0;
    w_push_entry.idx  = SB_IDX_W'(w_idx);
    w_push_entry.data = SB_DATA_W'(req_wdata) << {w_off_eff, 3'b000};
    w_push_entry.mask = mem_lane_mask(w_width, 3'(w_off_eff));
  end

  mem_store_buf #(.DEPTH(SB_DEPTH)) u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_st_go),
    .i_push_entry (w_push_entry),
    .i_pop        (w_drain),
    .i_cmp_idx    (SB_IDX_W'(w_idx)),
    .o_head       (w_head),
    .o_hit        (w_hit),
    .o_full       (w_sb_full),
    .o_empty      (sb_empty)
  );

  always_ff @(posedge clk) begin
    if (w_drain) begin
      for (int l = 0; l < LANES; l++) begin
        if (w_head.mask[l]) r_ram[w_head.idx[ADDR_WIDTH-1:0]][l*8 +: 8] <= w_head.data[l*8 +: 8];
      end
    end
  end

  assign w_rd_sh = SB_DATA_W'(r_ram[w_idx]) >> {w_off_eff, 3'b000};
  assign w_ext   = mem_extend(w_rd_sh, w_width, req_sign_ext);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_acc && !req_we;
      if (w_acc && !req_we) r_rdata <= w_mis ? '0 : w_ext[DATA_WIDTH-1:0];
    end
  end

  assign rdata       = r_rdata;
  assign rdata_valid = r_rvalid;

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
  logic r_mis;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_mis <= 1'b0;
    else        r_mis <= w_acc && w_mis;
  end
  assign misaligned = r_mis;
`else
  assign misaligned = 1'b0;
`endif

  assign w_unused = ^{req_addr, w_head, w_ext, w_size_m1};

endmodule

// File: tb/tb_mem_stage_sb.sv
// tb/tb_mem_stage_sb.sv - randomized bench for mem_stage_sb against a byte-array/queue model
module tb_mem_stage_sb;
  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int SBD   = 4;
  localparam int LANES = DW / 8;
  localparam int NB    = (1 << AW) * LANES;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we, req_sign_ext;
  logic [DW-1:0] req_addr, req_wdata, rdata;
  logic [1:0]    req_width;
  logic          rdata_valid, sb_empty, misaligned;

  mem_stage_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SB_DEPTH(SBD)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_width(req_width),
    .req_sign_ext(req_sign_ext), .rdata(rdata), .rdata_valid(rdata_valid),
    .sb_empty(sb_empty), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int unsigned   addr;
    int unsigned   size;
    logic [DW-1:0] data;
  } st_t;

  st_t           q[$];
  logic [7:0]    mem_b [NB];
  logic [DW-1:0] exp_rdata;
  logic          exp_valid;
  logic          exp_mis;

  function automatic int unsigned size_of(input logic [1:0] w);
    logic [1:0] e;
    e = (DW == 32 && w == 2'd3) ? 2'd2 : w;
    return 1 << e;
  endfunction

  function automatic bit is_mis(input logic [DW-1:0] a, input int unsigned sz);
    return MIS_EN && ((a % sz) != 0);
  endfunction

  function automatic int unsigned eff_addr(input logic [DW-1:0] a, input int unsigned sz);
    int unsigned b;
    b = a % NB;
    return MIS_EN ? b : b - (b % sz);
  endfunction

  function automatic bit model_hit(input logic [DW-1:0] a);
    int unsigned wi;
    wi = (a % NB) / LANES;
    foreach (q[i]) if (q[i].addr / LANES == wi) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] load_val(input int unsigned ea, input int unsigned sz, input logic se);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < sz; k++) v[8*k +: 8] = mem_b[ea+k];
    if (se && v[8*sz-1]) for (int b = 8*sz; b < 64; b++) v[b] = 1'b1;
    return v[DW-1:0];
  endfunction

  // One clock: drive at negedge, check ready, advance the model, check registered outputs after posedge.
  task automatic step(input logic v, input logic we, input logic [DW-1:0] a, input logic [DW-1:0] wd,
                      input logic [1:0] w, input logic se, output logic dut_acc);
    int unsigned sz;
    bit mr, macc, mis, ld_go;
    st_t e;
    @(negedge clk);
    req_valid = v; req_we = we; req_addr = a; req_wdata = wd; req_width = w; req_sign_ext = se;
    #1;
    sz  = size_of(w);
    mis = is_mis(a, sz);
    mr  = mis || (we ? (q.size() < SBD) : !model_hit(a));
    if (v) check_eq("req_ready", req_ready, mr);
    dut_acc = v && req_ready;
    macc    = v && mr;
    exp_mis   = macc && mis;
    exp_valid = macc && !we;
    ld_go     = macc && !we && !mis;
    if (exp_valid) exp_rdata = mis ? '0 : load_val(eff_addr(a, sz), sz, se);
    if (!ld_go && q.size() > 0) begin
      e = q.pop_front();
      for (int k = 0; k < e.size; k++) mem_b[e.addr+k] = e.data[8*k +: 8];
    end
    if (macc && we && !mis) begin
      e.addr = eff_addr(a, sz); e.size = sz; e.data = wd;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    check_eq("rdata_valid", rdata_valid, exp_valid);
    check_eq("rdata", rdata, exp_rdata);
    check_eq("sb_empty", sb_empty, q.size() == 0);
    check_eq("misaligned", misaligned, exp_mis);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 2'd0, 1'b0, acc);
  endtask

  task automatic do_req(input logic we, input logic [DW-1:0] a, input logic [DW-1:0] wd,
                        input logic [1:0] w, input logic se, output int stalls);
    logic acc;
    acc = 1'b0;
    stalls = 0;
    for (int n = 0; n < 20 && !acc; n++) begin
      step(1'b1, we, a, wd, w, se, acc);
      if (!acc) stalls++;
    end
    check_eq("req_accepted", acc, 1'b1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    q.delete();
    exp_valid = 1'b0; exp_rdata = '0; exp_mis = 1'b0;
    check_eq("rst_sb_empty", sb_empty, 1'b1);
    check_eq("rst_rdata_valid", rdata_valid, 1'b0);
    check_eq("rst_rdata", rdata, '0);
    check_eq("rst_misaligned", misaligned, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int st;
    logic acc;
    logic [DW-1:0] vals [4];
    logic [DW-1:0] pre;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_width = '0; req_sign_ext = 1'b0;
    apply_reset();

    for (int i = 0; i < 16; i++) do_req(1'b1, DW'(i*4), DW'($urandom), 2'd2, 1'b0, st);
    idle(3);

    // word store, drain while idle, then readback
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, st);
    idle(5);
    check_eq("t1_sb_empty", sb_empty, 1'b1);
    do_req(1'b0, 32'h10, '0, 2'd2, 1'b0, st);
    check_eq("t1_rdata", rdata, 32'hDEADBEEF);

    // load hazard on a fresh byte store, signed then unsigned
    do_req(1'b1, 32'h13, 32'h80, 2'd0, 1'b0, st);
    do_req(1'b0, 32'h13, '0, 2'd0, 1'b1, st);
    check_eq("t2_stalls", st, 1);
    check_eq("t2_signed", rdata, 32'hFFFFFF80);
    do_req(1'b0, 32'h13, '0, 2'd0, 1'b0, st);
    check_eq("t2_unsigned", rdata, 32'h00000080);

    // stores interleaved with non-hitting loads, then ordered readback
    for (int i = 0; i < 4; i++) begin
      vals[i] = $urandom;
      do_req(1'b1, DW'(32'h60 + i*4), vals[i], 2'd2, 1'b0, st);
      do_req(1'b0, 32'h0, '0, 2'd2, 1'b0, st);
    end
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, DW'(32'h60 + i*4), '0, 2'd2, 1'b0, st);
      check_eq("t3_readback", rdata, vals[i]);
    end

    // two stores to one word merge in order
    do_req(1'b1, 32'h40, 32'h11223344, 2'd2, 1'b0, st);
    do_req(1'b1, 32'h42, 32'h0000AAAA, 2'd1, 1'b0, st);
    do_req(1'b0, 32'h40, '0, 2'd2, 1'b0, st);
    check_eq("t4_merge", rdata, 32'hAAAA3344);

    // reset discards a buffered store
    idle(2);
    pre = load_val(32'h14, 4, 1'b0);
    do_req(1'b1, 32'h14, 32'hCAFEF00D, 2'd2, 1'b0, st);
    do_req(1'b0, 32'h0, '0, 2'd2, 1'b0, st);
    apply_reset();
    do_req(1'b0, 32'h14, '0, 2'd2, 1'b0, st);
    check_eq("t5_prestore", rdata, pre);

    // misaligned half access at 0x21
    do_req(1'b1, 32'h20, 32'h12345678, 2'd2, 1'b0, st);
    idle(3);
    do_req(1'b0, 32'h21, '0, 2'd1, 1'b0, st);
    check_eq("t6_rdata", rdata, MIS_EN ? 32'h0 : 32'h5678);
    check_eq("t6_misaligned", misaligned, MIS_EN);
    do_req(1'b1, 32'h21, 32'hBEEF, 2'd1, 1'b0, st);
    idle(3);
    do_req(1'b0, 32'h20, '0, 2'd2, 1'b0, st);
    check_eq("t6_ram", rdata, MIS_EN ? 32'h12345678 : 32'h1234BEEF);

    // randomized traffic over a small window with random ignored upper address bits
    for (int c = 0; c < 800; c++) begin
      logic          v, we, se;
      logic [1:0]    w;
      logic [DW-1:0] a, wd;
      v  = ($urandom_range(0, 9) < 7);
      we = ($urandom_range(0, 9) < 4);
      a  = ($urandom & 32'hFFFF_F000) | DW'($urandom_range(0, 63));
      wd = $urandom;
      w  = 2'($urandom_range(0, 3));
      se = 1'($urandom_range(0, 1));
      step(v, we, a, wd, w, se, acc);
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
